// File: rtl/image_pkg.sv
// Shared types and constants for the image write path.
// Contents:
//   arb_state_t      - arbiter state encoding (IDLE, STREAM, BLANK, WAIT_DONE)
//   R_MSB/G_MSB/B_MSB - bit offsets of the colour fields in a packed 24-bit pixel
//   clog2w()         - counter width for a given range, never less than 1 bit
package image_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    BLANK     = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int unsigned R_MSB = 23;
  localparam int unsigned G_MSB = 15;
  localparam int unsigned B_MSB = 7;

  // Bits needed to hold values 0..n-1; a single-entry range still gets 1 bit.
  function automatic int unsigned clog2w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Column/row position counter for one frame of WIDTH x HEIGHT pixels.
// Ports:
//   HCLK, HRESETn  - clock, asynchronous active-low reset
//   inc_i          - advance one pixel
//   clr_i          - return to column 0, row 0 (takes priority over inc_i)
//   last_col_o     - current column is WIDTH-1
//   last_pixel_o   - current position is the final pixel of the frame
// The counter wraps to 0/0 after the final pixel.
module frame_counter
  import image_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic inc_i,
  input  logic clr_i,
  output logic last_col_o,
  output logic last_pixel_o
);

  localparam int unsigned CW = clog2w(WIDTH);
  localparam int unsigned RW = clog2w(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_row;

  assign last_col_o   = (col_q == COL_LAST);
  assign last_row     = (row_q == ROW_LAST);
  assign last_pixel_o = last_col_o && last_row;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (inc_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/image_write_arbiter.sv
// Frame-granular round-robin arbiter sharing the BMP writer between two
// pixel-stream requesters. A requester owns the writer for a whole frame of
// WIDTH*HEIGHT pixels; the frame is released once the writer reports done.
// Ports:
//   HCLK, HRESETn            - clock, asynchronous active-low reset
//   req_valid[1:0]           - per-requester pixel valid
//   req0_rgb, req1_rgb       - requester pixels {R,G,B}
//   req_ready[1:0]           - per-requester ready (owner only, STREAM only)
//   hsync                    - pixel strobe to writer, one cycle after transfer
//   DATA_WRITE_R/G/B         - pixel to writer, held between strobes
//   write_done               - writer's done level
//   grant[1:0]               - one-hot frame owner, 0 when idle
//   busy                     - not IDLE
//   frame_done               - one-cycle pulse when a frame has been written
// Build option: define IMAGE_WRITE_ARBITER_HBLANK_INSERT_EN to insert HBLANK
// idle cycles after every row except the last.
module image_write_arbiter
  import image_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int HBLANK = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  req_valid,
  input  logic [23:0] req0_rgb,
  input  logic [23:0] req1_rgb,
  output logic [1:0]  req_ready,
  output logic        hsync,
  output logic [7:0]  DATA_WRITE_R,
  output logic [7:0]  DATA_WRITE_G,
  output logic [7:0]  DATA_WRITE_B,
  input  logic        write_done,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        frame_done
);

  arb_state_t  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        owner_q, owner_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        frame_done_q, frame_done_d;
  logic        hsync_q;
  logic [23:0] rgb_q;

  logic        xfer;
  logic        row_done;
  logic        cnt_clr;
  logic        last_col;
  logic        last_pixel;
  logic [23:0] owner_rgb;

`ifdef IMAGE_WRITE_ARBITER_HBLANK_INSERT_EN
  localparam int unsigned BW = clog2w(HBLANK + 1);
  logic [BW-1:0] blank_q, blank_d;
`else
  // Rows are back-to-back; HBLANK only matters when blanking is compiled in.
  if (HBLANK < 0) begin : g_hblank_unused
  end
`endif

  assign req_ready = (state_q == STREAM) ? grant_q : 2'b00;
  assign xfer      = |(req_valid & req_ready);
  assign row_done  = xfer && last_col;
  assign owner_rgb = owner_q ? req1_rgb : req0_rgb;

  frame_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_frame_counter (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .inc_i       (xfer),
    .clr_i       (cnt_clr),
    .last_col_o  (last_col),
    .last_pixel_o(last_pixel)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    frame_done_d = 1'b0;
    cnt_clr      = 1'b0;
`ifdef IMAGE_WRITE_ARBITER_HBLANK_INSERT_EN
    blank_d      = blank_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (|req_valid) begin
          owner_d = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
          grant_d = owner_d ? 2'b10 : 2'b01;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (row_done) begin
          if (last_pixel) begin
            state_d = WAIT_DONE;
          end
`ifdef IMAGE_WRITE_ARBITER_HBLANK_INSERT_EN
          else if (HBLANK > 0) begin
            state_d = BLANK;
            blank_d = BW'(HBLANK - 1);
          end
`endif
        end
      end
`ifdef IMAGE_WRITE_ARBITER_HBLANK_INSERT_EN
      BLANK: begin
        if (blank_q == '0) begin
          state_d = STREAM;
        end else begin
          blank_d = blank_q - BW'(1);
        end
      end
`endif
      WAIT_DONE: begin
        // hsync_q is high only in the first WAIT_DONE cycle (final pixel
        // strobe); the writer's done level is ignored there.
        if (write_done && !hsync_q) begin
          frame_done_d = 1'b1;
          grant_d      = 2'b00;
          rr_ptr_d     = ~owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= 1'b0;
      rr_ptr_q     <= 1'b0;
      frame_done_q <= 1'b0;
      hsync_q      <= 1'b0;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      frame_done_q <= frame_done_d;
      hsync_q      <= xfer;
      if (xfer) begin
        rgb_q <= owner_rgb;
      end
    end
  end

`ifdef IMAGE_WRITE_ARBITER_HBLANK_INSERT_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end
`endif

  assign hsync        = hsync_q;
  assign DATA_WRITE_R = rgb_q[R_MSB -: 8];
  assign DATA_WRITE_G = rgb_q[G_MSB -: 8];
  assign DATA_WRITE_B = rgb_q[B_MSB -: 8];
  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_image_write_arbiter.sv
module tb_image_write_arbiter;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int HB   = 3;
  localparam int NPIX = W * H;
`ifdef IMAGE_WRITE_ARBITER_HBLANK_INSERT_EN
  localparam int EXP_GAP = HB;
`else
  localparam int EXP_GAP = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [23:0] req0_rgb = '0;
  logic [23:0] req1_rgb = '0;
  logic [1:0]  req_ready;
  logic        hsync;
  logic [7:0]  DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B;
  logic        write_done = 1'b0;
  logic [1:0]  grant;
  logic        busy;
  logic        frame_done;

  int vec_cnt = 0;
  int err_cnt = 0;

  image_write_arbiter #(
    .WIDTH (W),
    .HEIGHT(H),
    .HBLANK(HB)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .req_valid   (req_valid),
    .req0_rgb    (req0_rgb),
    .req1_rgb    (req1_rgb),
    .req_ready   (req_ready),
    .hsync       (hsync),
    .DATA_WRITE_R(DATA_WRITE_R),
    .DATA_WRITE_G(DATA_WRITE_G),
    .DATA_WRITE_B(DATA_WRITE_B),
    .write_done  (write_done),
    .grant       (grant),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [30:0] all_outs();
    return {req_ready, hsync, DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B, grant, busy, frame_done};
  endfunction

  function automatic logic [23:0] pix();
    return {DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B};
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0; req_valid = 2'b00; req0_rgb = '0; req1_rgb = '0; write_done = 1'b0;
    tick(); tick();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1 HRESETn = 1'b0;
    #2;
    vec_cnt++;
    if (all_outs() !== 31'd0) begin
      err_cnt++; $display("FAIL reset_outs: got %h expected 0", all_outs());
    end
    tick(); tick();
    vec_cnt++;
    if (all_outs() !== 31'd0) begin
      err_cnt++; $display("FAIL reset_hold: got %h expected 0", all_outs());
    end
    HRESETn = 1'b1;
    tick();
    vec_cnt++;
    if ({busy, grant} !== 3'b000) begin
      err_cnt++; $display("FAIL reset_idle: got %b expected 000", {busy, grant});
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    req_valid = 2'b01; req0_rgb = '0;
    vec_cnt++;
    if (req_ready !== 2'b00) begin
      err_cnt++; $display("FAIL idle_ready: got %b expected 00", req_ready);
    end
    tick();
    vec_cnt++;
    if ({grant, busy, hsync} !== 4'b0110) begin
      err_cnt++; $display("FAIL first_grant: got %b expected 0110", {grant, busy, hsync});
    end
    for (int k = 0; k < NPIX; k++) begin
      req0_rgb = 24'(k);
      vec_cnt++;
      if (req_ready !== 2'b01) begin
        err_cnt++; $display("FAIL sf_ready[%0d]: got %b expected 01", k, req_ready);
      end
      tick();
      vec_cnt++;
      if (hsync !== 1'b1 || pix() !== 24'(k)) begin
        err_cnt++; $display("FAIL sf_pixel[%0d]: got hsync=%b data=%h expected hsync=1 data=%h", k, hsync, pix(), 24'(k));
      end
    end
    req_valid = 2'b00;
    vec_cnt++;
    if ({req_ready, busy} !== 3'b001) begin
      err_cnt++; $display("FAIL sf_wait_ready: got %b expected 001", {req_ready, busy});
    end
    tick();
    vec_cnt++;
    if ({hsync, frame_done} !== 2'b00) begin
      err_cnt++; $display("FAIL sf_after_last: got %b expected 00", {hsync, frame_done});
    end
    tick();
    write_done = 1'b1;
    tick();
    vec_cnt++;
    if ({frame_done, grant} !== 3'b100) begin
      err_cnt++; $display("FAIL sf_frame_done: got %b expected 100", {frame_done, grant});
    end
    write_done = 1'b0;
    tick();
    vec_cnt++;
    if ({frame_done, busy, grant} !== 4'b0000) begin
      err_cnt++; $display("FAIL sf_done_pulse: got %b expected 0000", {frame_done, busy, grant});
    end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_g;
    logic [23:0] base;
    do_reset();
    req_valid = 2'b11;
    for (int f = 0; f < 3; f++) begin
      exp_g = (f % 2 == 0) ? 2'b01 : 2'b10;
      base  = (f % 2 == 0) ? 24'h0A0000 : 24'h0B0000;
      tick();
      vec_cnt++;
      if (grant !== exp_g) begin
        err_cnt++; $display("FAIL fair_grant[%0d]: got %b expected %b", f, grant, exp_g);
      end
      for (int k = 0; k < NPIX; k++) begin
        req0_rgb = 24'h0A0000 | 24'(k);
        req1_rgb = 24'h0B0000 | 24'(k);
        vec_cnt++;
        if (req_ready !== exp_g) begin
          err_cnt++; $display("FAIL fair_ready[%0d.%0d]: got %b expected %b", f, k, req_ready, exp_g);
        end
        tick();
        vec_cnt++;
        if (hsync !== 1'b1 || pix() !== (base | 24'(k))) begin
          err_cnt++; $display("FAIL fair_pixel[%0d.%0d]: got hsync=%b data=%h expected 1 %h", f, k, hsync, pix(), base | 24'(k));
        end
      end
      // done raised during the final strobe cycle must not count yet
      write_done = 1'b1;
      vec_cnt++;
      if (req_ready !== 2'b00) begin
        err_cnt++; $display("FAIL fair_wait_ready[%0d]: got %b expected 00", f, req_ready);
      end
      tick();
      vec_cnt++;
      if (frame_done !== 1'b0) begin
        err_cnt++; $display("FAIL fair_early_done[%0d]: got %b expected 0", f, frame_done);
      end
      tick();
      vec_cnt++;
      if ({frame_done, grant} !== 3'b100) begin
        err_cnt++; $display("FAIL fair_done[%0d]: got %b expected 100", f, {frame_done, grant});
      end
      write_done = 1'b0;
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 2'b01;
    tick();
    for (int k = 0; k < NPIX; k++) begin
      if (k == 2) begin
        for (int s = 0; s < 5; s++) begin
          req_valid = 2'b00; req0_rgb = '1;
          tick();
          vec_cnt++;
          if ({hsync, req_ready, pix()} !== {1'b0, 2'b01, 24'h000101}) begin
            err_cnt++; $display("FAIL stall[%0d]: got hsync=%b ready=%b data=%h expected 0 01 000101", s, hsync, req_ready, pix());
          end
        end
      end
      req_valid = 2'b01; req0_rgb = 24'h000100 | 24'(k);
      vec_cnt++;
      if (req_ready !== 2'b01) begin
        err_cnt++; $display("FAIL stall_ready[%0d]: got %b expected 01", k, req_ready);
      end
      tick();
      vec_cnt++;
      if (hsync !== 1'b1 || pix() !== (24'h000100 | 24'(k))) begin
        err_cnt++; $display("FAIL stall_pixel[%0d]: got hsync=%b data=%h expected 1 %h", k, hsync, pix(), 24'h000100 | 24'(k));
      end
    end
    vec_cnt++;
    if ({req_ready, busy} !== 3'b001) begin
      err_cnt++; $display("FAIL stall_end: got %b expected 001", {req_ready, busy});
    end
    req_valid = 2'b00; write_done = 1'b1;
    tick(); tick();
    vec_cnt++;
    if (frame_done !== 1'b1) begin
      err_cnt++; $display("FAIL stall_done: got %b expected 1", frame_done);
    end
    write_done = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 2'b01;
    tick();
    for (int k = 0; k < 3; k++) begin
      req0_rgb = 24'h777700 | 24'(k);
      tick();
    end
    HRESETn = 1'b0;
    #1;
    vec_cnt++;
    if (all_outs() !== 31'd0) begin
      err_cnt++; $display("FAIL midreset_outs: got %h expected 0", all_outs());
    end
    tick();
    HRESETn = 1'b1;
    tick();
    vec_cnt++;
    if ({grant, hsync} !== 3'b010) begin
      err_cnt++; $display("FAIL midreset_regrant: got %b expected 010", {grant, hsync});
    end
    for (int k = 0; k < NPIX; k++) begin
      req0_rgb = 24'h004000 | 24'(k);
      vec_cnt++;
      if (req_ready !== 2'b01) begin
        err_cnt++; $display("FAIL midreset_ready[%0d]: got %b expected 01", k, req_ready);
      end
      tick();
      vec_cnt++;
      if (hsync !== 1'b1 || pix() !== (24'h004000 | 24'(k))) begin
        err_cnt++; $display("FAIL midreset_pixel[%0d]: got hsync=%b data=%h expected 1 %h", k, hsync, pix(), 24'h004000 | 24'(k));
      end
    end
    vec_cnt++;
    if ({req_ready, busy} !== 3'b001) begin
      err_cnt++; $display("FAIL midreset_end: got %b expected 001", {req_ready, busy});
    end
    req_valid = 2'b00; write_done = 1'b1;
    tick(); tick();
    vec_cnt++;
    if (frame_done !== 1'b1) begin
      err_cnt++; $display("FAIL midreset_done: got %b expected 1", frame_done);
    end
    write_done = 1'b0;
    tick();
  endtask

  task automatic test_write_done_late();
    do_reset();
    req_valid = 2'b01;
    tick();
    for (int k = 0; k < NPIX; k++) begin
      req0_rgb = 24'h00C000 | 24'(k);
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      vec_cnt++;
      if ({busy, req_ready, frame_done} !== 4'b1000) begin
        err_cnt++; $display("FAIL late_wait[%0d]: got %b expected 1000", c, {busy, req_ready, frame_done});
      end
      tick();
    end
    write_done = 1'b1;
    tick();
    vec_cnt++;
    if ({frame_done, grant} !== 3'b100) begin
      err_cnt++; $display("FAIL late_done: got %b expected 100", {frame_done, grant});
    end
    write_done = 1'b0; req_valid = 2'b00;
    tick();
    vec_cnt++;
    if ({frame_done, busy} !== 2'b00) begin
      err_cnt++; $display("FAIL late_pulse: got %b expected 00", {frame_done, busy});
    end
  endtask

  task automatic test_row_boundary();
    int gap;
    do_reset();
    req_valid = 2'b01;
    tick();
    for (int k = 0; k < NPIX; k++) begin
      req0_rgb = 24'h00E000 | 24'(k);
      gap = 0;
      while (req_ready !== 2'b01 && gap < 10) begin
        tick();
        gap++;
        vec_cnt++;
        if (hsync !== 1'b0) begin
          err_cnt++; $display("FAIL blank_hsync[%0d]: got %b expected 0", gap, hsync);
        end
      end
      vec_cnt++;
      if (gap !== ((k == W) ? EXP_GAP : 0)) begin
        err_cnt++; $display("FAIL row_gap[%0d]: got %0d expected %0d", k, gap, (k == W) ? EXP_GAP : 0);
      end
      tick();
      vec_cnt++;
      if (hsync !== 1'b1 || pix() !== (24'h00E000 | 24'(k))) begin
        err_cnt++; $display("FAIL row_pixel[%0d]: got hsync=%b data=%h expected 1 %h", k, hsync, pix(), 24'h00E000 | 24'(k));
      end
    end
    write_done = 1'b1; req_valid = 2'b00;
    vec_cnt++;
    if (req_ready !== 2'b00) begin
      err_cnt++; $display("FAIL row_last_ready: got %b expected 00", req_ready);
    end
    tick(); tick();
    vec_cnt++;
    if (frame_done !== 1'b1) begin
      err_cnt++; $display("FAIL row_last_done: got %b expected 1", frame_done);
    end
    write_done = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_fairness();
    test_stall();
    test_reset_mid();
    test_write_done_late();
    test_row_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
